// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-requester arbiter.
// Build option: define ARB_ROUND_ROBIN_EN for rotating priority (see req_arbiter4).
package arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;
   // Wide enough for a hold count up to MAX_HOLD-1 = 14
   localparam int HOLD_W  = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;

   // Binary requester index to one-hot grant vector
   function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_REQ-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/prio_enc4.sv
// Combinational 4-to-2 priority encoder with a rotate input.
// ROTATE_EN=1: the search starts at rot_i and moves upward, wrapping 3->0.
// ROTATE_EN=0: the request vector is bit-reversed before the same search, so
// with rot_i=0 the highest index wins (req[3] highest, req[0] lowest).
module prio_enc4
   import arb_pkg::*;
#(
   parameter bit ROTATE_EN = 1'b0
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   rot_i,
   output logic [IDX_W-1:0]   idx_o,
   output logic               valid_o
);

   logic [NUM_REQ-1:0] req_eff;
   logic [IDX_W-1:0]   cand;
   logic [IDX_W-1:0]   found;

   // Upward search from rot_i; walk lowest priority first so the last hit wins
   always_comb begin
      req_eff = req_i;
      cand    = '0;
      found   = '0;
      if (!ROTATE_EN) begin
         for (int b = 0; b < NUM_REQ; b++) begin
            req_eff[b] = req_i[NUM_REQ-1-b];
         end
      end
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         cand = rot_i + IDX_W'(k);
         if (req_eff[cand]) begin
            found = cand;
         end
      end
      // Undo the reversal in fixed mode: position i of req_eff is index 3-i
      idx_o   = ROTATE_EN ? found : ~found;
      valid_o = |req_i;
   end

endmodule

// File: rtl/req_arbiter4.sv
// Four-requester arbiter: IDLE -> GRANT -> RELEASE -> IDLE, registered
// one-hot grant, hold-limit revocation with a one-cycle timeout pulse.
// Build option: ARB_ROUND_ROBIN_EN selects rotating priority with a 2-bit
// pointer; without it the winner is fixed-priority (req[3] highest).
module req_arbiter4
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_id,
   output logic               grant_valid,
   output logic               timeout,
   output arb_state_t         dbg_state_o
);

   arb_state_t          state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]    id_q, id_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                timeout_q, timeout_d;

   logic [IDX_W-1:0]    rot;
   logic [IDX_W-1:0]    win_idx;
   logic                win_valid;
   logic                owner_req;
   logic                lim_hit;

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit ROT_EN = 1'b1;
   logic [IDX_W-1:0]    ptr_q, ptr_d;

   // Rotating-priority pointer: the requester searched first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

   assign rot = ptr_q;
`else
   localparam bit ROT_EN = 1'b0;
   assign rot = '0;
`endif

   prio_enc4 #(
      .ROTATE_EN (ROT_EN)
   ) u_prio_enc4 (
      .req_i   (req),
      .rot_i   (rot),
      .idx_o   (win_idx),
      .valid_o (win_valid)
   );

   assign owner_req = req[id_q];
   assign lim_hit   = (hold_q == HOLD_W'(MAX_HOLD - 1));

   // State, grant and counter registers; reset drops the grant without a clock
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         id_q      <= '0;
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         id_q      <= id_d;
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   // Next-state and next-output logic; en=0 outranks every GRANT exit cause
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      id_d      = id_q;
      hold_d    = hold_q;
      timeout_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_d     = ptr_q;
`endif
      case (state_q)
         IDLE: begin
            grant_d = '0;
            id_d    = '0;
            hold_d  = '0;
            if (en && win_valid) begin
               state_d = GRANT;
               grant_d = idx_to_onehot(win_idx);
               id_d    = win_idx;
            end
         end
         GRANT: begin
            if (!en) begin
               state_d = IDLE;
               grant_d = '0;
               id_d    = '0;
               hold_d  = '0;
            end else if (done || !owner_req || lim_hit) begin
               state_d   = RELEASE;
               grant_d   = '0;
               id_d      = '0;
               hold_d    = '0;
               // done wins over the hold limit: only a true revocation pulses
               timeout_d = lim_hit && !done && owner_req;
`ifdef ARB_ROUND_ROBIN_EN
               ptr_d     = id_q + IDX_W'(1);
`endif
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         RELEASE: begin
            state_d = IDLE;
            grant_d = '0;
            id_d    = '0;
            hold_d  = '0;
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            id_d    = '0;
            hold_d  = '0;
         end
      endcase
   end

   assign grant       = grant_q;
   assign grant_id    = id_q;
   assign grant_valid = |grant_q;
   assign timeout     = timeout_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_req_arbiter4.sv
// Directed bench for req_arbiter4 (MAX_HOLD=8). Round-robin scenarios are
// compiled in when ARB_ROUND_ROBIN_EN is defined, fixed-priority ones otherwise.
module tb_req_arbiter4;
   import arb_pkg::*;

   logic             clk;
   logic             rst;
   logic             en;
   logic [3:0]       req;
   logic             done;
   logic [3:0]       grant;
   logic [1:0]       grant_id;
   logic             grant_valid;
   logic             timeout;
   arb_state_t       dbg_state;
   logic [7:0]       outs;

   int n_checks;
   int n_errors;

   // {grant, grant_id, grant_valid, timeout}
   assign outs = {grant, grant_id, grant_valid, timeout};

   req_arbiter4 #(.MAX_HOLD(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_id    (grant_id),
      .grant_valid (grant_valid),
      .timeout     (timeout),
      .dbg_state_o (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; req = 4'b0000; done = 1'b0;
      repeat (2) tick();
      n_checks++; if (outs !== 8'b0000_00_0_0) begin n_errors++; $display("FAIL reset_outs: got %b want %b", outs, 8'b0000_00_0_0); end
      n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
      rst = 1'b0;
      tick();
      n_checks++; if (outs !== 8'b0000_00_0_0) begin n_errors++; $display("FAIL post_reset_idle: got %b want %b", outs, 8'b0000_00_0_0); end
   endtask

`ifndef ARB_ROUND_ROBIN_EN
   logic [3:0] pt_req [4] = '{4'b1000, 4'b0011, 4'b0001, 4'b1111};
   logic [3:0] pt_gnt [4] = '{4'b1000, 4'b0010, 4'b0001, 4'b1000};
   logic [1:0] pt_id  [4] = '{2'd3,    2'd1,    2'd0,    2'd3};

   task automatic test_fixed_grant();
      req = 4'b0110; en = 1'b1;
      tick();
      n_checks++; if (outs !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin n_errors++; $display("FAIL fixed_first_grant: got %b want %b", outs, {4'b0100, 2'd2, 1'b1, 1'b0}); end
      n_checks++; if (dbg_state !== GRANT) begin n_errors++; $display("FAIL fixed_state_grant: got %0d want %0d", dbg_state, GRANT); end
      done = 1'b1;
      tick();
      done = 1'b0;
      n_checks++; if (outs !== 8'b0000_00_0_0) begin n_errors++; $display("FAIL done_release: got %b want %b", outs, 8'b0000_00_0_0); end
      n_checks++; if (dbg_state !== RELEASE) begin n_errors++; $display("FAIL done_state_release: got %0d want %0d", dbg_state, RELEASE); end
      tick();
      n_checks++; if (outs !== 8'b0000_00_0_0) begin n_errors++; $display("FAIL gap_idle: got %b want %b", outs, 8'b0000_00_0_0); end
      tick();
      n_checks++; if (outs !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin n_errors++; $display("FAIL fixed_regrant: got %b want %b", outs, {4'b0100, 2'd2, 1'b1, 1'b0}); end
      req = 4'b0000;
      repeat (2) tick();
   endtask

   task automatic test_fixed_priority();
      for (int i = 0; i < 4; i++) begin
         req = pt_req[i]; en = 1'b1;
         tick();
         n_checks++; if (outs !== {pt_gnt[i], pt_id[i], 1'b1, 1'b0}) begin n_errors++; $display("FAIL prio_%0d: req=%b got %b want %b", i, pt_req[i], outs, {pt_gnt[i], pt_id[i], 1'b1, 1'b0}); end
         req = 4'b0000;
         tick();
         n_checks++; if (outs !== 8'b0000_00_0_0) begin n_errors++; $display("FAIL prio_drop_%0d: got %b want %b", i, outs, 8'b0000_00_0_0); end
         tick();
      end
   endtask
`endif

   task automatic test_idle_hold();
      en = 1'b0; req = 4'b1111; done = 1'b1;
      repeat (2) tick();
      n_checks++; if (outs !== 8'b0000_00_0_0) begin n_errors++; $display("FAIL en_low_idle: got %b want %b", outs, 8'b0000_00_0_0); end
      en = 1'b1; req = 4'b0000;
      tick();
      n_checks++; if (outs !== 8'b0000_00_0_0) begin n_errors++; $display("FAIL no_req_idle: got %b want %b", outs, 8'b0000_00_0_0); end
      // done is high while in IDLE and must not stop the grant
      req = 4'b0100;
      tick();
      n_checks++; if (outs !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin n_errors++; $display("FAIL done_ignored_idle: got %b want %b", outs, {4'b0100, 2'd2, 1'b1, 1'b0}); end
      tick();
      done = 1'b0; req = 4'b0000;
      tick();
   endtask

   task automatic test_timeout();
      req = 4'b0001; en = 1'b1; done = 1'b0;
      tick();
      n_checks++; if (outs !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin n_errors++; $display("FAIL hold_cycle_0: got %b want %b", outs, {4'b0001, 2'd0, 1'b1, 1'b0}); end
      for (int c = 1; c < 8; c++) begin
         tick();
         n_checks++; if (outs !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin n_errors++; $display("FAIL hold_cycle_%0d: got %b want %b", c, outs, {4'b0001, 2'd0, 1'b1, 1'b0}); end
      end
      tick();
      n_checks++; if (outs !== {4'b0000, 2'd0, 1'b0, 1'b1}) begin n_errors++; $display("FAIL timeout_pulse: got %b want %b", outs, {4'b0000, 2'd0, 1'b0, 1'b1}); end
      tick();
      n_checks++; if (outs !== 8'b0000_00_0_0) begin n_errors++; $display("FAIL timeout_single: got %b want %b", outs, 8'b0000_00_0_0); end
      tick();
      n_checks++; if (outs !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin n_errors++; $display("FAIL timeout_regrant: got %b want %b", outs, {4'b0001, 2'd0, 1'b1, 1'b0}); end
      req = 4'b0000;
      tick();
      n_checks++; if (outs !== 8'b0000_00_0_0) begin n_errors++; $display("FAIL req_drop_no_timeout: got %b want %b", outs, 8'b0000_00_0_0); end
      tick();
   endtask

   task automatic test_done_at_limit();
      req = 4'b0001; en = 1'b1; done = 1'b0;
      tick();
      repeat (7) tick();
      n_checks++; if (outs !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin n_errors++; $display("FAIL limit_last_hold: got %b want %b", outs, {4'b0001, 2'd0, 1'b1, 1'b0}); end
      done = 1'b1;
      tick();
      done = 1'b0; req = 4'b0000;
      n_checks++; if (outs !== 8'b0000_00_0_0) begin n_errors++; $display("FAIL done_beats_limit: got %b want %b", outs, 8'b0000_00_0_0); end
      n_checks++; if (dbg_state !== RELEASE) begin n_errors++; $display("FAIL done_limit_state: got %0d want %0d", dbg_state, RELEASE); end
      tick();
      n_checks++; if (timeout !== 1'b0) begin n_errors++; $display("FAIL done_limit_no_pulse: got %b want %b", timeout, 1'b0); end
   endtask

   task automatic test_en_drop();
      req = 4'b0010; en = 1'b1;
      tick();
      n_checks++; if (outs !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin n_errors++; $display("FAIL en_drop_grant: got %b want %b", outs, {4'b0010, 2'd1, 1'b1, 1'b0}); end
      en = 1'b0;
      tick();
      n_checks++; if (outs !== 8'b0000_00_0_0) begin n_errors++; $display("FAIL en_drop_clear: got %b want %b", outs, 8'b0000_00_0_0); end
      n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL en_drop_state: got %0d want %0d", dbg_state, IDLE); end
      en = 1'b1;
      tick();
      n_checks++; if (outs !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin n_errors++; $display("FAIL en_restore_regrant: got %b want %b", outs, {4'b0010, 2'd1, 1'b1, 1'b0}); end
      req = 4'b0000;
      repeat (2) tick();
   endtask

`ifdef ARB_ROUND_ROBIN_EN
   logic [1:0] rr_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

   task automatic test_round_robin();
      rst = 1'b1; en = 1'b0; req = 4'b0000; done = 1'b0;
      tick();
      rst = 1'b0;
      req = 4'b1111; en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++; if (outs !== {idx_to_onehot(rr_id[i]), rr_id[i], 1'b1, 1'b0}) begin n_errors++; $display("FAIL rr_seq_%0d: got %b want %b", i, outs, {idx_to_onehot(rr_id[i]), rr_id[i], 1'b1, 1'b0}); end
         done = 1'b1;
         tick();
         done = 1'b0;
         n_checks++; if (outs !== 8'b0000_00_0_0) begin n_errors++; $display("FAIL rr_gap_%0d: got %b want %b", i, outs, 8'b0000_00_0_0); end
         tick();
      end
      // pointer now at 1: grant 1, drop en, pointer must stay at 1
      tick();
      n_checks++; if (outs !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin n_errors++; $display("FAIL rr_pre_drop: got %b want %b", outs, {4'b0010, 2'd1, 1'b1, 1'b0}); end
      en = 1'b0;
      tick();
      n_checks++; if (outs !== 8'b0000_00_0_0) begin n_errors++; $display("FAIL rr_en_drop: got %b want %b", outs, 8'b0000_00_0_0); end
      en = 1'b1;
      tick();
      n_checks++; if (outs !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin n_errors++; $display("FAIL rr_ptr_kept: got %b want %b", outs, {4'b0010, 2'd1, 1'b1, 1'b0}); end
      req = 4'b0000;
      repeat (2) tick();
   endtask
`endif

   task automatic test_reset_mid_grant();
      req = 4'b0100; en = 1'b1; done = 1'b0;
      tick();
      n_checks++; if (outs !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin n_errors++; $display("FAIL pre_reset_grant: got %b want %b", outs, {4'b0100, 2'd2, 1'b1, 1'b0}); end
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (outs !== 8'b0000_00_0_0) begin n_errors++; $display("FAIL async_reset_drop: got %b want %b", outs, 8'b0000_00_0_0); end
      n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL async_reset_state: got %0d want %0d", dbg_state, IDLE); end
      req = 4'b1000;
      tick();
      rst = 1'b0;
      tick();
      n_checks++; if (outs !== {4'b1000, 2'd3, 1'b1, 1'b0}) begin n_errors++; $display("FAIL post_reset_grant: got %b want %b", outs, {4'b1000, 2'd3, 1'b1, 1'b0}); end
      req = 4'b0000;
      repeat (2) tick();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
`ifndef ARB_ROUND_ROBIN_EN
      test_fixed_grant();
      test_fixed_priority();
`endif
      test_idle_hold();
      test_timeout();
      test_done_at_limit();
      test_en_drop();
`ifdef ARB_ROUND_ROBIN_EN
      test_round_robin();
`endif
      test_reset_mid_grant();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
